seq_ctrl: RTL and testbench

SEQ_CTRL -- requirements
Module: seq_ctrl

---
 rtl/seq_ctrl_pkg.sv | 31 +++
 rtl/seq_ctrl_icode_class.sv | 12 +
 rtl/seq_ctrl.sv | 99 +++++++++
 tb/tb_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared icode constants, state encodings, stat codes and `BYTE/`WORD widths
`ifndef SEQ_CTRL_DEFS
`define SEQ_CTRL_DEFS
`define BYTE 8
`define WORD 32
`endif
package seq_ctrl_pkg;
  localparam logic [`BYTE-1:0] I_HALT   = 8'h00;
  localparam logic [`BYTE-1:0] I_NOP    = 8'h01;
  localparam logic [`BYTE-1:0] I_RRMOVL = 8'h02;
  localparam logic [`BYTE-1:0] I_IRMOVL = 8'h03;
  localparam logic [`BYTE-1:0] I_RMMOVL = 8'h04;
  localparam logic [`BYTE-1:0] I_MRMOVL = 8'h05;
  localparam logic [`BYTE-1:0] I_OPL    = 8'h06;
  localparam logic [`BYTE-1:0] I_JXX    = 8'h07;
  localparam logic [`BYTE-1:0] I_CALL   = 8'h08;
  localparam logic [`BYTE-1:0] I_RET    = 8'h09;
  localparam logic [`BYTE-1:0] I_PUSHL  = 8'h0A;
  localparam logic [`BYTE-1:0] I_POPL   = 8'h0B;
  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_PCUPDATE  = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;
endpackage

// File: rtl/seq_ctrl_icode_class.sv
// icode_class: combinational icode decode into memory use, register write and legality
module icode_class import seq_ctrl_pkg::*; (
  input  logic [`BYTE-1:0] icode_i,
  output logic             needs_mem_o,
  output logic             writes_reg_o,
  output logic             valid_o
);
  assign needs_mem_o  = icode_i inside {I_RMMOVL, I_MRMOVL, I_CALL, I_RET, I_PUSHL, I_POPL};
  assign writes_reg_o = icode_i inside {I_RRMOVL, I_IRMOVL, I_MRMOVL, I_OPL, I_CALL, I_RET, I_PUSHL, I_POPL};
  assign valid_o      = icode_i inside {I_HALT, I_NOP, I_RRMOVL, I_IRMOVL, I_RMMOVL, I_MRMOVL,
                                        I_OPL, I_JXX, I_CALL, I_RET, I_PUSHL, I_POPL};
endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle fetch/decode/execute/memory/writeback/pc sequencer with sticky halt
// Optional performance counters enabled by defining PERF_CNT_EN.
module seq_ctrl import seq_ctrl_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic [`BYTE-1:0] icode_i,
  input  logic             instr_valid_i,
  input  logic             mem_ready_i,
  input  logic             stat_err_i,
  output logic             fetch_en_o,
  output logic             decode_en_o,
  output logic             ex_en_o,
  output logic             mem_req_o,
  output logic             wb_en_o,
  output logic             pc_we_o,
  output logic [2:0]       state_o,
  output logic             halt_o,
  output logic [1:0]       stat_o
`ifdef PERF_CNT_EN
  ,
  output logic [`WORD-1:0] instr_cnt_o,
  output logic [`WORD-1:0] cycle_cnt_o
`endif
);
  logic [2:0]       state_q, state_d;
  logic [1:0]       stat_q, stat_d;
  logic [`BYTE-1:0] icode_q, icode_d, cls_icode;
  logic             needs_mem, writes_reg, valid;
  // The single classifier looks at the incoming icode while fetching, the latched one afterwards
  assign cls_icode = state_q == S_FETCH ? icode_i : icode_q;
  icode_class u_cls (
    .icode_i      (cls_icode),
    .needs_mem_o  (needs_mem),
    .writes_reg_o (writes_reg),
    .valid_o      (valid)
  );
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    case (state_q)
      S_FETCH: if (instr_valid_i) begin
        icode_d = icode_i;
        if (stat_err_i) {state_d, stat_d} = {S_HALT, STAT_ADR};
        else if (icode_i == I_HALT) {state_d, stat_d} = {S_HALT, STAT_HLT};
        else if (!valid) {state_d, stat_d} = {S_HALT, STAT_INS};
        else state_d = S_DECODE;
      end
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = needs_mem ? S_MEMORY : S_WRITEBACK;
      S_MEMORY:    if (stat_err_i) {state_d, stat_d} = {S_HALT, STAT_ADR};
                   else if (mem_ready_i) state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_PCUPDATE;
      S_PCUPDATE:  state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     {state_d, stat_d} = {S_HALT, STAT_INS};
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      stat_q  <= STAT_AOK;
      icode_q <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
    end
  end
  assign fetch_en_o  = state_q == S_FETCH;
  assign decode_en_o = state_q == S_DECODE;
  assign ex_en_o     = state_q == S_EXECUTE;
  assign mem_req_o   = state_q == S_MEMORY;
  assign wb_en_o     = state_q == S_WRITEBACK && writes_reg;
  assign pc_we_o     = state_q == S_PCUPDATE;
  assign halt_o      = state_q == S_HALT;
  assign state_o     = state_q;
  assign stat_o      = stat_q;
`ifdef PERF_CNT_EN
  localparam logic [`WORD-1:0] ONE = `WORD'(1);
  logic [`WORD-1:0] instr_cnt_q, instr_cnt_d, cycle_cnt_q, cycle_cnt_d;
  // Both counters saturate rather than wrap
  always_comb begin
    instr_cnt_d = state_q == S_PCUPDATE && ~&instr_cnt_q ? instr_cnt_q + ONE : instr_cnt_q;
    cycle_cnt_d = state_q != S_HALT && ~&cycle_cnt_q ? cycle_cnt_q + ONE : cycle_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end
  assign instr_cnt_o = instr_cnt_q;
  assign cycle_cnt_o = cycle_cnt_q;
`endif
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: table vectors, directed corner sequences and randomized instruction streams
// checked against a per-instruction trace model; counter checks only with PERF_CNT_EN.
module tb_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] icode_i = '0;
  logic       instr_valid_i = 1'b0, mem_ready_i = 1'b0, stat_err_i = 1'b0;
  logic       fetch_en_o, decode_en_o, ex_en_o, mem_req_o, wb_en_o, pc_we_o, halt_o;
  logic [2:0] state_o;
  logic [1:0] stat_o;
`ifdef PERF_CNT_EN
  logic [31:0] instr_cnt_o, cycle_cnt_o;
`endif
  int          n_cmp = 0, n_bad = 0;
  logic [2:0]  cur = 3'd0;
  logic [1:0]  cur_stat = 2'd0;
  logic [7:0]  cur_ic = 8'd0;
  logic [31:0] exp_instr = 0, exp_cyc = 0;

  always #5 clk = ~clk;

  seq_ctrl dut (
    .clk(clk), .rst(rst), .icode_i(icode_i), .instr_valid_i(instr_valid_i),
    .mem_ready_i(mem_ready_i), .stat_err_i(stat_err_i), .fetch_en_o(fetch_en_o),
    .decode_en_o(decode_en_o), .ex_en_o(ex_en_o), .mem_req_o(mem_req_o), .wb_en_o(wb_en_o),
    .pc_we_o(pc_we_o), .state_o(state_o), .halt_o(halt_o), .stat_o(stat_o)
`ifdef PERF_CNT_EN
    , .instr_cnt_o(instr_cnt_o), .cycle_cnt_o(cycle_cnt_o)
`endif
  );

  function automatic bit is_mem(input logic [7:0] ic);
    return ic inside {8'h04, 8'h05, 8'h08, 8'h09, 8'h0A, 8'h0B};
  endfunction
  function automatic bit is_wr(input logic [7:0] ic);
    return ic inside {8'h02, 8'h03, 8'h05, 8'h06, 8'h08, 8'h09, 8'h0A, 8'h0B};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state_o), 32'(cur));
    chk("stat", 32'(stat_o), 32'(cur_stat));
    chk("outputs", 32'({fetch_en_o, decode_en_o, ex_en_o, mem_req_o, wb_en_o, pc_we_o, halt_o}),
        32'({cur == 3'd0, cur == 3'd1, cur == 3'd2, cur == 3'd3,
             cur == 3'd4 && is_wr(cur_ic), cur == 3'd5, cur == 3'd6}));
`ifdef PERF_CNT_EN
    chk("instr_cnt", instr_cnt_o, exp_instr);
    chk("cycle_cnt", cycle_cnt_o, exp_cyc);
`endif
  endtask

  task automatic drive(input logic [7:0] ic, input logic v, input logic r, input logic e);
    icode_i = ic;
    instr_valid_i = v;
    mem_ready_i = r;
    stat_err_i = e;
  endtask

  task automatic noise();
    drive(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Advance one clock; the caller states which state/stat the trace should reach
  task automatic step(input logic [2:0] nxt, input logic [1:0] nst);
    if (rst) begin
      exp_cyc = 0;
      exp_instr = 0;
      cur_ic = 0;
    end else begin
      if (cur != 3'd6) exp_cyc = exp_cyc + 1;
      if (cur == 3'd5) exp_instr = exp_instr + 1;
    end
    @(posedge clk);
    #1;
    cur = nxt;
    cur_stat = nst;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    noise();
    step(3'd0, 2'd0);
    rst = 1'b0;
  endtask

  // Expected trace of one instruction built from the sequencing rules
  task automatic run_instr(input logic [7:0] ic, input int vd, input int md, input bit ferr, input bit merr);
    for (int i = 0; i < vd; i++) begin
      drive(8'($urandom), 1'b0, 1'($urandom), 1'($urandom));
      step(3'd0, cur_stat);
    end
    drive(ic, 1'b1, 1'($urandom), ferr);
    cur_ic = ic;
    if (ferr) step(3'd6, 2'd2);
    else if (ic == 8'h00) step(3'd6, 2'd1);
    else if (ic > 8'h0B) step(3'd6, 2'd3);
    else begin
      step(3'd1, cur_stat);
      noise(); step(3'd2, cur_stat);
      noise(); step(is_mem(ic) ? 3'd3 : 3'd4, cur_stat);
      if (is_mem(ic)) begin
        for (int i = 0; i < md; i++) begin
          drive(8'($urandom), 1'($urandom), 1'b0, 1'b0);
          step(3'd3, cur_stat);
        end
        drive(8'($urandom), 1'($urandom), merr ? 1'($urandom) : 1'b1, merr);
        if (merr) step(3'd6, 2'd2); else step(3'd4, cur_stat);
      end
      if (cur == 3'd4) begin
        noise(); step(3'd5, cur_stat);
        noise(); step(3'd0, cur_stat);
      end
    end
  endtask

  typedef struct { logic [7:0] ic; bit err; logic [2:0] st; logic [1:0] stat; } fvec_t;
  typedef struct { logic [7:0] ic; logic [2:0] st; bit wb; } evec_t;
  fvec_t ftab[9];
  evec_t etab[11];

  initial begin
    int cnt;
    ftab[0] = '{8'h00, 1'b0, 3'd6, 2'd1};
    ftab[1] = '{8'h0C, 1'b0, 3'd6, 2'd3};
    ftab[2] = '{8'hFF, 1'b0, 3'd6, 2'd3};
    ftab[3] = '{8'h0F, 1'b0, 3'd6, 2'd3};
    ftab[4] = '{8'h0B, 1'b0, 3'd1, 2'd0};
    ftab[5] = '{8'h01, 1'b0, 3'd1, 2'd0};
    ftab[6] = '{8'h00, 1'b1, 3'd6, 2'd2};
    ftab[7] = '{8'h05, 1'b1, 3'd6, 2'd2};
    ftab[8] = '{8'hFF, 1'b1, 3'd6, 2'd2};
    etab[0]  = '{8'h01, 3'd4, 1'b0};
    etab[1]  = '{8'h02, 3'd4, 1'b1};
    etab[2]  = '{8'h03, 3'd4, 1'b1};
    etab[3]  = '{8'h04, 3'd3, 1'b0};
    etab[4]  = '{8'h05, 3'd3, 1'b1};
    etab[5]  = '{8'h06, 3'd4, 1'b1};
    etab[6]  = '{8'h07, 3'd4, 1'b0};
    etab[7]  = '{8'h08, 3'd3, 1'b1};
    etab[8]  = '{8'h09, 3'd3, 1'b1};
    etab[9]  = '{8'h0A, 3'd3, 1'b1};
    etab[10] = '{8'h0B, 3'd3, 1'b1};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      do_reset();
      drive(ftab[i].ic, 1'b1, 1'b0, ftab[i].err);
      cur_ic = ftab[i].ic;
      step(ftab[i].st, ftab[i].stat);
    end
    for (int i = 0; i < 11; i++) begin
      do_reset();
      drive(etab[i].ic, 1'b1, 1'b0, 1'b0);
      cur_ic = etab[i].ic;
      step(3'd1, 2'd0);
      step(3'd2, 2'd0);
      step(etab[i].st, 2'd0);
      if (etab[i].st == 3'd3) begin
        drive(etab[i].ic, 1'b0, 1'b1, 1'b0);
        step(3'd4, 2'd0);
      end
      chk("tab_wb_en", 32'(wb_en_o), 32'(etab[i].wb));
      step(3'd5, 2'd0);
      step(3'd0, 2'd0);
    end

    // IRMOVL: 5-cycle path, writes back, one retired instruction
    do_reset();
    drive(8'h03, 1'b1, 1'b0, 1'b0); cur_ic = 8'h03;
    step(3'd1, 2'd0); step(3'd2, 2'd0); step(3'd4, 2'd0);
    chk("irmovl_wb", 32'(wb_en_o), 32'd1);
    step(3'd5, 2'd0); step(3'd0, 2'd0);
`ifdef PERF_CNT_EN
    chk("irmovl_instr_cnt", instr_cnt_o, 32'd1);
`endif
    // MRMOVL with mem_ready three cycles late
    do_reset();
    drive(8'h05, 1'b1, 1'b0, 1'b0); cur_ic = 8'h05;
    step(3'd1, 2'd0); step(3'd2, 2'd0); step(3'd3, 2'd0);
    cnt = 32'(mem_req_o);
    for (int i = 0; i < 3; i++) begin
      drive(8'h05, 1'b0, 1'b0, 1'b0);
      step(3'd3, 2'd0);
      cnt += 32'(mem_req_o);
    end
    drive(8'h05, 1'b0, 1'b1, 1'b0);
    step(3'd4, 2'd0);
    chk("mrmovl_req_cycles", 32'(cnt), 32'd4);
    chk("mrmovl_wb", 32'(wb_en_o), 32'd1);
    step(3'd5, 2'd0); step(3'd0, 2'd0);
    // HALT instruction is sticky and freezes the active-cycle count
    do_reset();
    drive(8'h00, 1'b1, 1'b0, 1'b0); cur_ic = 8'h00;
    step(3'd6, 2'd1);
    chk("halt_o", 32'(halt_o), 32'd1);
    chk("halt_stat", 32'(stat_o), 32'd1);
    repeat (10) begin noise(); step(3'd6, 2'd1); end
    chk("halt_sticky", 32'(state_o), 32'd6);
`ifdef PERF_CNT_EN
    chk("halt_cyc_frozen", cycle_cnt_o, 32'd1);
`endif
    // Illegal icode, then an address fault racing mem_ready
    do_reset();
    drive(8'h0F, 1'b1, 1'b0, 1'b0); cur_ic = 8'h0F;
    step(3'd6, 2'd3);
    chk("ins_stat", 32'(stat_o), 32'd3);
    do_reset();
    drive(8'h05, 1'b1, 1'b0, 1'b0); cur_ic = 8'h05;
    step(3'd1, 2'd0); step(3'd2, 2'd0); step(3'd3, 2'd0);
    drive(8'h05, 1'b0, 1'b1, 1'b1);
    step(3'd6, 2'd2);
    chk("adr_stat", 32'(stat_o), 32'd2);
    // Reset while a memory request is pending
    do_reset();
    drive(8'h05, 1'b1, 1'b0, 1'b0); cur_ic = 8'h05;
    step(3'd1, 2'd0); step(3'd2, 2'd0); step(3'd3, 2'd0);
    rst = 1'b1; drive(8'h05, 1'b0, 1'b0, 1'b0);
    step(3'd0, 2'd0);
    rst = 1'b0;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_stat", 32'(stat_o), 32'd0);
`ifdef PERF_CNT_EN
    chk("rst_counters", instr_cnt_o | cycle_cnt_o, 32'd0);
`endif
    // RMMOVL writes no register; JXX goes straight to writeback
    do_reset();
    drive(8'h04, 1'b1, 1'b0, 1'b0); cur_ic = 8'h04;
    step(3'd1, 2'd0); step(3'd2, 2'd0); step(3'd3, 2'd0);
    drive(8'h04, 1'b0, 1'b1, 1'b0);
    step(3'd4, 2'd0);
    chk("rmmovl_wb", 32'(wb_en_o), 32'd0);
    step(3'd5, 2'd0); step(3'd0, 2'd0);
    drive(8'h07, 1'b1, 1'b0, 1'b0); cur_ic = 8'h07;
    step(3'd1, 2'd0); step(3'd2, 2'd0); step(3'd4, 2'd0);
    chk("jxx_skip_mem", 32'(state_o), 32'd4);
    step(3'd5, 2'd0); step(3'd0, 2'd0);

    // Random instruction streams; each halt is observed a while then cleared by reset
    do_reset();
    repeat (300) begin
      run_instr(8'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
      if (cur == 3'd6) begin
        repeat (3) begin noise(); step(3'd6, cur_stat); end
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
